instr_dispatch: RTL
===================

INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, the number of cycles each instruction is held on the output (legal range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the entries per requester queue (power of two, at least 2).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  3  bit k: port k offers a request.
REQ-007 req_payload  input  36  port k payload in bits [12k+11:12k], packed as {op[11], addr[10:8], data[7:0]}; op 0 = read, 1 = write.
REQ-008 req_ready  output  3  bit k: port k queue can accept a request.
REQ-009 instruction  output  14  {id[13:12], op[11], addr[10:8], data[7:0]}; this is the coherence-system instruction input.
REQ-010 instr_active  output  1  high while instruction carries a real (non-NOP) request.
REQ-011 issue_count  output  16  count of dispatched instructions.

Function
REQ-012 A request on port k SHALL be accepted in a cycle where req_valid[k] and req_ready[k] are both high, and pushed into queue k.
REQ-013 req_ready[k] SHALL equal NOT full(k), computed from registered state only; a full queue does not accept a request even when a pop happens in the same cycle.
REQ-014 Each queue SHALL preserve FIFO order; a simultaneous push and pop on a non-full, non-empty queue SHALL keep its occupancy unchanged.
REQ-015 FSM states SHALL be IDLE, HOLD and GAP.
REQ-016 In IDLE with at least one queue non-empty, the block SHALL grant round-robin starting from pointer rr (rr, rr+1, rr+2, modulo 3), pop the head of the granted queue and go to HOLD.
REQ-017 After a grant to port k, rr SHALL become (k+1) mod 3.
REQ-018 In IDLE with all queues empty, the FSM SHALL stay in IDLE.
REQ-019 On a grant in cycle N, instruction SHALL be {k[1:0], payload} from cycle N+1 through cycle N+HOLD_CYCLES, held stable, with instr_active high.
REQ-020 The hold counter SHALL load HOLD_CYCLES-1 on grant and decrement each HOLD cycle; when it reaches 0 the FSM SHALL go to GAP.
REQ-021 GAP SHALL last exactly one cycle and then go to IDLE, so back-to-back identical instructions are separated by NOP.
REQ-022 Outside HOLD, instruction SHALL be NOP = 14'h3000 (id 2'b11, no cache selected) and instr_active SHALL be 0.
REQ-023 Maximum throughput SHALL be one instruction per HOLD_CYCLES+2 cycles.
REQ-024 issue_count SHALL increment by 1 on each grant and wrap from 16'hFFFF to 0.
REQ-025 instruction and instr_active SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-026 Reset SHALL empty all queues, set the FSM to IDLE, rr to 0, the hold counter to 0 and issue_count to 0, and drive instruction to 14'h3000 and instr_active to 0 in the cycle after reset is sampled.
REQ-027 Reset asserted during HOLD SHALL abort the instruction and discard all queued requests.
REQ-028 Requests presented while reset is high SHALL not be accepted, and req_ready SHALL be 0 during reset.

Structure
REQ-029 A shared package SHALL hold: the NOP encoding, the cache ID codes 2'b00/2'b01/2'b10, the instruction field positions, the FSM state encoding and the default HOLD_CYCLES.
REQ-030 The per-port queue SHALL be one sub-module, instr_fifo (12-bit data, FIFO_DEPTH entries, full/empty flags), instantiated three times.

Verification
REQ-031 Single request: port 1 pushes {1, 3'b101, 8'hA5} from idle -> instruction 14'h1DA5 for exactly 4 cycles starting 1 cycle after the grant, then 14'h3000; issue_count = 1.
REQ-032 Three simultaneous requests with rr = 0: port 0 data 8'h10, port 1 data 8'h11, port 2 data 8'h12 -> dispatch order 0, 1, 2, each followed by at least one NOP cycle; rr ends at 0.
REQ-033 Full queue: push 3 requests to port 2 while the FSM is busy -> req_ready[2] = 0 after 2 accepted, the third is held off, and the accepted two are dispatched in order.
REQ-034 Reset during HOLD (cycle 2 of 4) with 1 entry queued -> output NOP the next cycle, queue empty, and no later dispatch of the queued request.
REQ-035 Identical back-to-back requests: two copies of 14'h0812 on port 0 -> two hold windows separated by exactly 2 NOP cycles (GAP then IDLE).
REQ-036 Counter wrap: preload the scenario to 16'hFFFF dispatches (or force the count) -> the next grant drives issue_count to 0.

Source files
------------

// File: rtl/instr_dispatch_pkg.sv
// rtl/instr_dispatch_pkg.sv - shared encodings, field positions and helpers for instr_dispatch
package instr_dispatch_pkg;

    localparam int NUM_PORTS           = 3;
    localparam int PAYLOAD_W           = 12;
    localparam int INSTR_W             = 14;
    localparam int DEFAULT_HOLD_CYCLES = 4;

    // Cache ID codes; ID_NONE selects no cache and marks the NOP word
    localparam logic [1:0] ID_CACHE0 = 2'b00;
    localparam logic [1:0] ID_CACHE1 = 2'b01;
    localparam logic [1:0] ID_CACHE2 = 2'b10;
    localparam logic [1:0] ID_NONE   = 2'b11;

    localparam logic [INSTR_W-1:0] INSTR_NOP = {ID_NONE, 12'h000};

    // Instruction field positions; the payload shares bits [11:0] with the instruction
    localparam int ID_MSB   = 13;
    localparam int ID_LSB   = 12;
    localparam int OP_BIT   = 11;
    localparam int ADDR_MSB = 10;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] port_to_id(input logic [1:0] p);
        case (p)
            2'd0:    return ID_CACHE0;
            2'd1:    return ID_CACHE1;
            default: return ID_CACHE2;
        endcase
    endfunction

    function automatic logic [INSTR_W-1:0] make_instr(input logic [1:0] id,
                                                      input logic [PAYLOAD_W-1:0] payload);
        logic [INSTR_W-1:0] instr;
        instr                     = '0;
        instr[ID_MSB:ID_LSB]      = id;
        instr[OP_BIT]             = payload[OP_BIT];
        instr[ADDR_MSB:ADDR_LSB]  = payload[ADDR_MSB:ADDR_LSB];
        instr[DATA_MSB:DATA_LSB]  = payload[DATA_MSB:DATA_LSB];
        return instr;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - per-port request queue with full/empty flags
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full queue is dropped even if a pop happens in the same cycle
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer, occupancy and storage update; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_dispatch.sv
// rtl/instr_dispatch.sv - three-port round-robin dispatcher holding each instruction for HOLD_CYCLES
module instr_dispatch
    import instr_dispatch_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*PAYLOAD_W-1:0] req_payload,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic [INSTR_W-1:0]             instruction,
    output logic                           instr_active,
    output logic [15:0]                    issue_count
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    logic [NUM_PORTS-1:0]                fifo_full;
    logic [NUM_PORTS-1:0]                fifo_empty;
    logic [NUM_PORTS-1:0]                fifo_pop;
    logic [NUM_PORTS-1:0][PAYLOAD_W-1:0] fifo_head;

    state_e               state_q;
    logic [1:0]           rr_q;
    logic [3:0]           hold_q;
    logic [15:0]          count_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 active_q;

    logic                 grant_valid;
    logic [1:0]           grant_port;
    logic [1:0]           cand1;
    logic [1:0]           cand2;

    // Ready depends only on queue state and reset, never on this cycle's pop
    assign req_ready = ~fifo_full & {NUM_PORTS{~reset}};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        instr_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (PAYLOAD_W)
        ) u_fifo (
            .clk_i   (clock),
            .rst_i   (reset),
            .push_i  (req_valid[g] & req_ready[g]),
            .pop_i   (fifo_pop[g]),
            .wdata_i (req_payload[g*PAYLOAD_W +: PAYLOAD_W]),
            .rdata_o (fifo_head[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

    // Round-robin pick: first non-empty queue searching rr, rr+1, rr+2
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = rr_q;
        cand1       = next_port(rr_q);
        cand2       = next_port(cand1);
        if (!fifo_empty[rr_q]) begin
            grant_valid = 1'b1;
            grant_port  = rr_q;
        end else if (!fifo_empty[cand1]) begin
            grant_valid = 1'b1;
            grant_port  = cand1;
        end else if (!fifo_empty[cand2]) begin
            grant_valid = 1'b1;
            grant_port  = cand2;
        end
    end

    // Pop the granted head only on the IDLE cycle that issues the grant
    always_comb begin
        fifo_pop = '0;
        if (state_q == ST_IDLE && grant_valid) begin
            fifo_pop[grant_port] = 1'b1;
        end
    end

    // Dispatch FSM: IDLE grants, HOLD keeps the word stable, GAP forces one NOP before the next grant
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_q     <= 2'd0;
            hold_q   <= 4'd0;
            count_q  <= 16'd0;
            instr_q  <= INSTR_NOP;
            active_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        instr_q  <= make_instr(port_to_id(grant_port), fifo_head[grant_port]);
                        active_q <= 1'b1;
                        hold_q   <= HOLD_LOAD;
                        rr_q     <= next_port(grant_port);
                        count_q  <= count_q + 16'd1;
                        state_q  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == 4'd0) begin
                        instr_q  <= INSTR_NOP;
                        active_q <= 1'b0;
                        state_q  <= ST_GAP;
                    end else begin
                        hold_q <= hold_q - 4'd1;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign instruction  = instr_q;
    assign instr_active = active_q;
    assign issue_count  = count_q;

endmodule
